// File: rtl/vscale_retire_trace_buffer.sv
// Retire trace capture buffer for vscale_core.
// Stamps FP-side and integer-side retire/exception events with a free-running
// cycle counter, packs them into fixed records and queues them in a FIFO that
// drains through a valid/ready stream. Events that find no room are dropped
// and counted; the FIFO never stalls the core.
module vscale_retire_trace_buffer #(
    parameter int DEPTH   = 16,
    parameter int CYC_W   = 16,
    parameter int ECODE_W = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     int_valid,
    input  logic [31:0]              int_pc,
    input  logic [31:0]              int_inst,
    input  logic                     int_wr_reg,
    input  logic [4:0]               int_rd,
    input  logic [31:0]              int_wdata,
    input  logic                     fp_valid,
    input  logic [31:0]              fp_pc,
    input  logic [31:0]              fp_inst,
    input  logic [4:0]               fp_rd,
    input  logic [31:0]              fp_wdata,
    input  logic                     exc_valid,
    input  logic [31:0]              exc_pc,
    input  logic [ECODE_W-1:0]       exc_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_kind,
    output logic [CYC_W-1:0]         out_cycle,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    output logic [4:0]               out_reg,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              drop_count,
    output logic                     overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [1:0] KIND_INT = 2'd0;
    localparam logic [1:0] KIND_FP  = 2'd1;
    localparam logic [1:0] KIND_EXC = 2'd2;

    typedef struct packed {
        logic [1:0]       kind;
        logic [CYC_W-1:0] cycle;
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [4:0]       rd;
        logic [31:0]      data;
    } rec_t;

    logic [CYC_W-1:0] cycle_q, cycle_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_nx;
    logic [CNT_W-1:0] count_q, count_d, free;
    logic [15:0]      drop_q, drop_d;
    logic [16:0]      drop_sum;
    logic             overflow_q, overflow_d;
    logic             pop, fp_req, is_req, fp_push, is_push;
    logic [1:0]       n_push, n_drop;
    rec_t             fp_rec, is_rec, first_rec, head;
    rec_t             mem_q [DEPTH];

    // Build the two candidate records; an exception displaces the int retire.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        fp_rec = '0;
        is_rec = '0;
        fp_rec.kind  = KIND_FP;
        fp_rec.cycle = cycle_q;
        fp_rec.pc    = fp_pc;
        fp_rec.inst  = fp_inst;
        fp_rec.rd    = fp_rd;
        fp_rec.data  = fp_wdata;
        is_rec.cycle = cycle_q;
        if (exc_valid) begin
            is_rec.kind = KIND_EXC;
            is_rec.pc   = exc_pc;
            is_rec.data = 32'(exc_code);
        end else begin
            is_rec.kind = KIND_INT;
            is_rec.pc   = int_pc;
            is_rec.inst = int_inst;
            if (int_wr_reg && (int_rd != 5'd0)) begin
                is_rec.rd   = int_rd;
                is_rec.data = int_wdata;
            end
        end
    end

    // Space accounting, push/drop decisions and next-state for all counters.
    always_comb begin
        pop       = (count_q != '0) && out_ready;
        free      = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
        fp_req    = enable && fp_valid;
        is_req    = enable && (exc_valid || int_valid);
        fp_push   = fp_req && (free != '0);
        // The FP record is older, so it claims the first free slot.
        is_push   = is_req && (free > CNT_W'(fp_push));
        n_push    = 2'(fp_push) + 2'(is_push);
        n_drop    = 2'(fp_req && !fp_push) + 2'(is_req && !is_push);
        first_rec = fp_push ? fp_rec : is_rec;
        wr_ptr_nx = wr_ptr_q + AW'(1);

        cycle_d    = cycle_q + CYC_W'(1);
        count_d    = count_q + CNT_W'(n_push) - CNT_W'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(n_push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        drop_sum   = {1'b0, drop_q} + 17'(n_drop);
        drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d = overflow_q || (n_drop != 2'd0);
    end

    // Control state: counter, pointers, occupancy and drop statistics.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!resetn) begin
            cycle_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    // Record storage: up to two consecutive slots written per cycle.
    always_ff @(posedge clk) begin
        // NOTE: the record array has no reset; pointers and count define
        // which entries are live, so stale contents are never observed.
        if (fp_push || is_push) begin
            mem_q[wr_ptr_q] <= first_rec;
        end
        if (fp_push && is_push) begin
            mem_q[wr_ptr_nx] <= is_rec;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign out_kind   = head.kind;
    assign out_cycle  = head.cycle;
    assign out_pc     = head.pc;
    assign out_inst   = head.inst;
    assign out_reg    = head.rd;
    assign out_data   = head.data;
    assign count      = count_q;
    assign drop_count = drop_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_vscale_retire_trace_buffer.sv
// Directed self-checking bench for vscale_retire_trace_buffer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vscale_retire_trace_buffer;

    localparam int DEPTH   = 16;
    localparam int CYC_W   = 16;
    localparam int ECODE_W = 4;

    logic               clk;
    logic               resetn;
    logic               enable;
    logic               int_valid;
    logic [31:0]        int_pc;
    logic [31:0]        int_inst;
    logic               int_wr_reg;
    logic [4:0]         int_rd;
    logic [31:0]        int_wdata;
    logic               fp_valid;
    logic [31:0]        fp_pc;
    logic [31:0]        fp_inst;
    logic [4:0]         fp_rd;
    logic [31:0]        fp_wdata;
    logic               exc_valid;
    logic [31:0]        exc_pc;
    logic [ECODE_W-1:0] exc_code;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_kind;
    logic [CYC_W-1:0]   out_cycle;
    logic [31:0]        out_pc;
    logic [31:0]        out_inst;
    logic [4:0]         out_reg;
    logic [31:0]        out_data;
    logic [4:0]         count;
    logic [15:0]        drop_count;
    logic               overflow;

    int checks;
    int failures;
    int cyc_ref;
    int stamp;

    vscale_retire_trace_buffer #(
        .DEPTH(DEPTH), .CYC_W(CYC_W), .ECODE_W(ECODE_W)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .int_valid(int_valid), .int_pc(int_pc), .int_inst(int_inst),
        .int_wr_reg(int_wr_reg), .int_rd(int_rd), .int_wdata(int_wdata),
        .fp_valid(fp_valid), .fp_pc(fp_pc), .fp_inst(fp_inst),
        .fp_rd(fp_rd), .fp_wdata(fp_wdata),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_code(exc_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_cycle(out_cycle), .out_pc(out_pc), .out_inst(out_inst),
        .out_reg(out_reg), .out_data(out_data), .count(count),
        .drop_count(drop_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: rising edge updates the DUT, then settle at the falling edge.
    task automatic step();
        @(posedge clk);
        cyc_ref = (cyc_ref + 1) & 32'hFFFF;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        int_valid  = 1'b0; int_pc = '0; int_inst = '0; int_wr_reg = 1'b0;
        int_rd     = '0;   int_wdata = '0;
        fp_valid   = 1'b0; fp_pc = '0; fp_inst = '0; fp_rd = '0; fp_wdata = '0;
        exc_valid  = 1'b0; exc_pc = '0; exc_code = '0;
    endtask

    task automatic drive_int(input logic [31:0] pc, input logic [31:0] inst,
                             input logic wr, input logic [4:0] rd, input logic [31:0] data);
        int_valid = 1'b1; int_pc = pc; int_inst = inst;
        int_wr_reg = wr;  int_rd = rd; int_wdata = data;
    endtask

    task automatic drive_fp(input logic [31:0] pc, input logic [31:0] inst,
                            input logic [4:0] rd, input logic [31:0] data);
        fp_valid = 1'b1; fp_pc = pc; fp_inst = inst; fp_rd = rd; fp_wdata = data;
    endtask

    initial begin
        checks = 0; failures = 0; cyc_ref = 0;
        resetn = 1'b0; enable = 1'b1; out_ready = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_ovf", overflow, 0);
        resetn = 1'b1; cyc_ref = 0;

        // Single int retire captured at stamp 3.
        repeat (3) step();
        out_ready = 1'b1;
        drive_int(32'h200, 32'h00500093, 1'b1, 5'd1, 32'd5);
        step(); clear_inputs();
        check("t1_valid", out_valid, 1);
        check("t1_kind", out_kind, 0);
        check("t1_cycle", out_cycle, 3);
        check("t1_pc", out_pc, 32'h200);
        check("t1_inst", out_inst, 32'h00500093);
        check("t1_reg", out_reg, 1);
        check("t1_data", out_data, 5);
        check("t1_count", count, 1);
        step();
        check("t1_count_end", count, 0);
        check("t1_valid_end", out_valid, 0);

        // Dual capture: FP first, INT with rd=0 has reg/data zeroed.
        out_ready = 1'b0; stamp = cyc_ref;
        drive_fp(32'h204, 32'h00107053, 5'd2, 32'h3F800000);
        drive_int(32'h208, 32'h00000013, 1'b1, 5'd0, 32'hDEAD);
        step(); clear_inputs();
        check("t2_count", count, 2);
        check("t2_fp_kind", out_kind, 1);
        check("t2_fp_pc", out_pc, 32'h204);
        check("t2_fp_reg", out_reg, 2);
        check("t2_fp_data", out_data, 32'h3F800000);
        check("t2_fp_cycle", out_cycle, 64'(stamp));
        out_ready = 1'b1;
        step();
        check("t2_int_kind", out_kind, 0);
        check("t2_int_pc", out_pc, 32'h208);
        check("t2_int_reg", out_reg, 0);
        check("t2_int_data", out_data, 0);
        check("t2_int_cycle", out_cycle, 64'(stamp));
        step();
        check("t2_count_end", count, 0);

        // Overfill with 20 retires while the sink stalls.
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_int(32'h1000 + 32'(4 * i), 32'h13, 1'b1, 5'(i + 1), 32'(i + 100));
            step();
            if (i == 0) check("t3_head_first", out_pc, 32'h1000);
        end
        clear_inputs();
        check("t3_count", count, 16);
        check("t3_drop", drop_count, 4);
        check("t3_ovf", overflow, 1);
        check("t3_head_pc", out_pc, 32'h1000);
        check("t3_head_data", out_data, 100);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_drain_pc", out_pc, 64'(32'h1000 + 32'(4 * i)));
            step();
        end
        check("t3_count_end", count, 0);
        check("t3_valid_end", out_valid, 0);

        // Full FIFO with pop: single pushes accepted, dual push drops INT.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_int(32'h3000 + 32'(4 * i), 32'h13, 1'b1, 5'd3, 32'(i));
            step();
        end
        clear_inputs();
        check("t4_full", count, 16);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_int(32'h4000 + 32'(4 * i), 32'h13, 1'b1, 5'd4, 32'(i));
            step();
        end
        clear_inputs();
        check("t4_single_count", count, 16);
        check("t4_single_drop", drop_count, 4);
        drive_fp(32'h5000, 32'h00107053, 5'd7, 32'h40000000);
        drive_int(32'h5004, 32'h13, 1'b1, 5'd5, 32'h55);
        step(); clear_inputs();
        check("t4_dual_drop", drop_count, 5);
        check("t4_dual_count", count, 16);
        check("t4_head_pc", out_pc, 32'h3010);
        repeat (15) step();
        check("t4_last_kind", out_kind, 1);
        check("t4_last_pc", out_pc, 32'h5000);
        step();
        check("t4_count_end", count, 0);

        // Exception wins over int retire in the same cycle.
        out_ready = 1'b0;
        exc_valid = 1'b1; exc_pc = 32'h600; exc_code = 4'd2;
        drive_int(32'h604, 32'h13, 1'b1, 5'd6, 32'h66);
        step(); clear_inputs();
        check("t5_count", count, 1);
        check("t5_kind", out_kind, 2);
        check("t5_pc", out_pc, 32'h600);
        check("t5_inst", out_inst, 0);
        check("t5_reg", out_reg, 0);
        check("t5_data", out_data, 2);
        for (int i = 0; i < 2; i++) begin
            drive_int(32'h610 + 32'(4 * i), 32'h13, 1'b1, 5'd8, 32'(i));
            step();
        end
        clear_inputs();
        out_ready = 1'b1;
        step();
        check("t5_middrain", count, 2);
        #2 resetn = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_count", count, 0);
        check("t5_rst_drop", drop_count, 0);
        check("t5_rst_ovf", overflow, 0);
        @(negedge clk);
        resetn = 1'b1; cyc_ref = 0;

        // Capture disabled: nothing queued, nothing counted as dropped.
        enable = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_int(32'h800 + 32'(4 * i), 32'h13, 1'b1, 5'd9, 32'(i));
            step();
        end
        clear_inputs();
        check("t6_count", count, 0);
        check("t6_drop", drop_count, 0);
        enable = 1'b1;

        // Cycle stamp wrap from 0xFFFF to 0x0000.
        while (cyc_ref != 32'hFFFF) step();
        drive_int(32'h700, 32'h13, 1'b1, 5'd10, 32'h70);
        step();
        drive_int(32'h704, 32'h13, 1'b1, 5'd11, 32'h71);
        step(); clear_inputs();
        check("t7_count", count, 2);
        check("t7_stamp_hi", out_cycle, 16'hFFFF);
        out_ready = 1'b1;
        step();
        check("t7_pc", out_pc, 32'h704);
        check("t7_stamp_wrap", out_cycle, 16'h0000);
        step();
        check("t7_count_end", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
